// File: rtl/struct_nibble_rx_if.sv
// struct_nibble_rx_if: nibble stream in, assembled record out, plus debug drop count
// master drives in_valid/in_data/out_ready; slave (the receiver) drives the rest.
// Ports: in_valid/in_ready/in_data (nibble link), out_valid/out_ready/out_data/out_err (record), drop_cnt (debug)
interface struct_nibble_rx_if #(parameter int PAYLOAD_NIBBLES = 4);
  logic                         in_valid;
  logic                         in_ready;
  logic [3:0]                   in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [4*PAYLOAD_NIBBLES-1:0] out_data;
  logic                         out_err;
  logic [7:0]                   drop_cnt;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_err, drop_cnt);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_err, drop_cnt);
endinterface

// File: rtl/struct_nibble_rx.sv
// struct_nibble_rx: hunts for a header nibble and assembles the following payload nibbles into one record
// Ports: clk, rst_n (sync active-low), bus (struct_nibble_rx_if.slave).
// Optional STRUCT_RX_CSUM_EN: frame carries a trailing XOR checksum nibble; mismatch raises out_err.
module struct_nibble_rx #(
  parameter int         PAYLOAD_NIBBLES = 4,
  parameter logic [3:0] HDR             = 4'h5
) (
  input logic              clk,
  input logic              rst_n,
  struct_nibble_rx_if.slave bus
);
  localparam int W  = 4 * PAYLOAD_NIBBLES;
  localparam int IW = $clog2(PAYLOAD_NIBBLES + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t        state;
  logic [IW-1:0] idx;
  logic          acc;
`ifdef STRUCT_RX_CSUM_EN
  logic [3:0]    csum;
`endif
  assign acc = bus.in_valid & bus.in_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_err   <= 1'b0;
      bus.drop_cnt  <= '0;
`ifdef STRUCT_RX_CSUM_EN
      csum          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (acc) begin
            if (bus.in_data == HDR) begin
              state <= COLLECT;
              idx   <= '0;
`ifdef STRUCT_RX_CSUM_EN
              csum  <= '0;
`endif
            end else begin
              bus.drop_cnt <= bus.drop_cnt + {7'd0, bus.drop_cnt != 8'hFF};
            end
          end
        end
        COLLECT: begin
          if (acc) begin
`ifdef STRUCT_RX_CSUM_EN
            if (idx == IW'(PAYLOAD_NIBBLES)) begin
              state         <= HOLD;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
              bus.out_err   <= bus.in_data != csum;
            end else begin
              bus.out_data <= (bus.out_data << 4) | W'(bus.in_data);
              csum         <= csum ^ bus.in_data;
              idx          <= idx + IW'(1);
            end
`else
            // shifting left puts the first payload nibble in the MSB after N nibbles
            bus.out_data <= (bus.out_data << 4) | W'(bus.in_data);
            idx          <= idx + IW'(1);
            if (idx == IW'(PAYLOAD_NIBBLES - 1)) begin
              state         <= HOLD;
              bus.in_ready  <= 1'b0;
              bus.out_valid <= 1'b1;
            end
`endif
          end
        end
        default: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_struct_nibble_rx.sv
// tb_struct_nibble_rx: directed self-checking bench for struct_nibble_rx (N=4, HDR=5)
module tb_struct_nibble_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  struct_nibble_rx_if #(.PAYLOAD_NIBBLES(4)) bus ();
  struct_nibble_rx #(.PAYLOAD_NIBBLES(4), .HDR(4'h5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 4'h0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] d);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 4'h0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %0b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'h0) begin n_bad++; $display("FAIL rst_out_data: got %h want 0000", bus.out_data); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL rst_out_err: got %0b want 0", bus.out_err); end
    n_cmp++; if (bus.drop_cnt !== 8'h0) begin n_bad++; $display("FAIL rst_drop_cnt: got %h want 00", bus.drop_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [3:0] v [5] = '{4'h5, 4'h1, 4'h2, 4'h3, 4'h4};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid[%0d]: got %0b want 0", i, bus.out_valid); end
      send(v[i]);
    end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %0b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'h1234) begin n_bad++; $display("FAIL basic_data: got %h want 1234", bus.out_data); end
    n_cmp++; if (bus.drop_cnt !== 8'h00) begin n_bad++; $display("FAIL basic_drop: got %h want 00", bus.drop_cnt); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_one_cycle: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready_after: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_drop();
    logic [3:0] v [7] = '{4'h7, 4'hA, 4'h5, 4'hB, 4'hC, 4'hD, 4'hE};
    do_reset();
    bus.out_ready = 1'b1;
    foreach (v[i]) send(v[i]);
    @(negedge clk);
    n_cmp++; if (bus.drop_cnt !== 8'd2) begin n_bad++; $display("FAIL drop_cnt: got %h want 02", bus.drop_cnt); end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL drop_valid: got %0b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'hBCDE) begin n_bad++; $display("FAIL drop_data: got %h want bcde", bus.out_data); end
  endtask

  task automatic test_backpressure();
    logic [3:0] v [5] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    @(negedge clk);
    bus.out_ready = 1'b0;
    foreach (v[i]) send(v[i]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, bus.out_valid); end
      n_cmp++; if (bus.out_data !== 16'h6789) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want 6789", i, bus.out_data); end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_gaps();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(4'h5);
      @(negedge clk);
      if (i < 4) begin
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL gap_early_valid[%0d]: got %0b want 0", i, bus.out_valid); end
      end
    end
    n_cmp++; if (bus.out_data !== 16'h5555) begin n_bad++; $display("FAIL gap_data: got %h want 5555", bus.out_data); end
    n_cmp++; if (bus.drop_cnt !== 8'h00) begin n_bad++; $display("FAIL gap_drop: got %h want 00", bus.drop_cnt); end
  endtask

  task automatic test_midframe_reset();
    logic [3:0] v [5] = '{4'h5, 4'h9, 4'h8, 4'h7, 4'h6};
    do_reset();
    bus.out_ready = 1'b1;
    send(4'h5); send(4'h1); send(4'h2);
    do_reset();
    n_cmp++; if (bus.out_data !== 16'h0) begin n_bad++; $display("FAIL mid_rst_data: got %h want 0000", bus.out_data); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_early_valid[%0d]: got %0b want 0", i, bus.out_valid); end
      send(v[i]);
      @(negedge clk);
    end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_rst_valid: got %0b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'h9876) begin n_bad++; $display("FAIL mid_rst_data_out: got %h want 9876", bus.out_data); end
    n_cmp++; if (bus.drop_cnt !== 8'h00) begin n_bad++; $display("FAIL mid_rst_drop: got %h want 00", bus.drop_cnt); end
  endtask

`ifdef STRUCT_RX_CSUM_EN
  task automatic test_csum();
    logic [3:0] v [5] = '{4'h5, 4'h1, 4'h2, 4'h3, 4'h4};
    do_reset();
    bus.out_ready = 1'b1;
    foreach (v[i]) send(v[i]);
    send(4'h4);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL csum_ok_valid: got %0b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL csum_ok_err: got %0b want 0", bus.out_err); end
    foreach (v[i]) send(v[i]);
    send(4'hF);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL csum_bad_valid: got %0b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_err !== 1'b1) begin n_bad++; $display("FAIL csum_bad_err: got %0b want 1", bus.out_err); end
    n_cmp++; if (bus.out_data !== 16'h1234) begin n_bad++; $display("FAIL csum_bad_data: got %h want 1234", bus.out_data); end
  endtask
`endif

  task automatic test_saturate();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(4'h0);
      if (i == 254) begin
        n_cmp++; if (bus.drop_cnt !== 8'hFF) begin n_bad++; $display("FAIL sat_at_255: got %h want ff", bus.drop_cnt); end
      end
      if (i == 99) begin
        n_cmp++; if (bus.drop_cnt !== 8'd100) begin n_bad++; $display("FAIL sat_at_100: got %h want 64", bus.drop_cnt); end
      end
    end
    @(negedge clk);
    n_cmp++; if (bus.drop_cnt !== 8'hFF) begin n_bad++; $display("FAIL sat_drop: got %h want ff", bus.drop_cnt); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL sat_valid: got %0b want 0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 4'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_drop();
    test_backpressure();
    test_gaps();
    test_midframe_reset();
`ifdef STRUCT_RX_CSUM_EN
    test_csum();
`endif
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
